// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Opcode encodings and FSM state type for the MEM-stage LSU.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam logic [3:0] DMRD_NONE = 4'd0;
    localparam logic [3:0] LW        = 4'd1;
    localparam logic [3:0] LH        = 4'd2;
    localparam logic [3:0] LHU       = 4'd3;
    localparam logic [3:0] LB        = 4'd4;
    localparam logic [3:0] LBU       = 4'd5;

    localparam logic [1:0] DMWR_NONE = 2'd0;
    localparam logic [1:0] SW        = 2'd1;
    localparam logic [1:0] SH        = 2'd2;
    localparam logic [1:0] SB        = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the addressed lane of a read word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    always_comb begin
        case (i_op)
            LW:      o_data = i_rdata;
            LH:      o_data = {{16{w_half[15]}}, w_half};
            LHU:     o_data = {16'h0000, w_half};
            LB:      o_data = {{24{w_byte[7]}}, w_byte};
            LBU:     o_data = {24'h000000, w_byte};
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store unit with req/ack memory handshake,
//               stall generation, misalignment and timeout detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exmem_valid,
    input  logic [3:0]        exmem_dmrd,
    input  logic [1:0]        exmem_dmwr,
    input  logic [ADDR_W-1:0] exmem_addr,
    input  logic [31:0]       exmem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              mem_stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        r_is_load;
    logic [3:0]  r_op;
    logic [1:0]  r_lane;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_access;
    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_start;
    logic        w_mis;
    logic        w_stall;
    logic        w_ack_hit;
    logic        w_timeout;
    logic [31:0] w_ext;

    // A load opcode outranks a simultaneous store opcode.
    assign w_is_load  = exmem_valid && (exmem_dmrd >= LW) && (exmem_dmrd <= LBU);
    assign w_is_store = exmem_valid && !w_is_load && (exmem_dmwr != DMWR_NONE);
    assign w_access   = w_is_load || w_is_store;

    always_comb begin
        w_aligned = 1'b1;
        w_be      = 4'b1111;
        w_wdata   = exmem_wdata;
        if (w_is_load) begin
            if (exmem_dmrd == LW)
                w_aligned = (exmem_addr[1:0] == 2'b00);
            else if (exmem_dmrd == LH || exmem_dmrd == LHU)
                w_aligned = !exmem_addr[0];
        end else begin
            case (exmem_dmwr)
                SW: w_aligned = (exmem_addr[1:0] == 2'b00);
                SH: begin
                    w_aligned = !exmem_addr[0];
                    w_be      = exmem_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata   = {2{exmem_wdata[15:0]}};
                end
                SB: begin
                    w_be    = 4'b0001 << exmem_addr[1:0];
                    w_wdata = {4{exmem_wdata[7:0]}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_mis     = 1'b0;
        w_stall   = 1'b0;
        w_ack_hit = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_aligned) begin
                        w_stall = 1'b1;
                        w_start = 1'b1;
                        w_next  = BUSY;
                    end else begin
                        w_mis = 1'b1;
                    end
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (mem_ack) begin
                    w_ack_hit = 1'b1;
                    w_next    = DONE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign mem_stall = w_stall && !rst;

    load_align u_load_align (
        .i_rdata   (mem_rdata),
        .i_op      (r_op),
        .i_addr_lo (r_lane),
        .o_data    (w_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= 4'b0000;
            mem_wdata    <= 32'h0000_0000;
            load_data    <= 32'h0000_0000;
            load_valid   <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            r_cnt        <= 8'd0;
            r_is_load    <= 1'b0;
            r_op         <= DMRD_NONE;
            r_lane       <= 2'b00;
        end else begin
            misalign_err <= w_mis;
            bus_err      <= w_timeout;
            load_valid   <= r_is_load && (w_ack_hit || w_timeout);
            if (w_start) begin
                mem_req   <= 1'b1;
                mem_we    <= w_is_store;
                mem_addr  <= {exmem_addr[ADDR_W-1:2], 2'b00};
                mem_be    <= w_be;
                mem_wdata <= w_wdata;
                r_is_load <= w_is_load;
                r_op      <= exmem_dmrd;
                r_lane    <= exmem_addr[1:0];
                r_cnt     <= 8'd0;
            end else if (w_ack_hit || w_timeout) begin
                mem_req <= 1'b0;
                if (r_is_load)
                    load_data <= w_ack_hit ? w_ext : 32'h0000_0000;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed plus randomized self-checking bench for the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        exmem_valid;
    logic [3:0]  exmem_dmrd;
    logic [1:0]  exmem_dmwr;
    logic [31:0] exmem_addr;
    logic [31:0] exmem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign_err;
    logic        bus_err;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_ld   = 32'h0;

    mem_access_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .exmem_valid  (exmem_valid),
        .exmem_dmrd   (exmem_dmrd),
        .exmem_dmwr   (exmem_dmwr),
        .exmem_addr   (exmem_addr),
        .exmem_wdata  (exmem_wdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    // Reference model: access size in bytes for the decoded operation.
    function automatic int op_size(input bit ld, input logic [3:0] rd, input logic [1:0] wr);
        if (ld) return (rd == 4'd1) ? 4 : (rd == 4'd2 || rd == 4'd3) ? 2 : 1;
        return (wr == 2'd1) ? 4 : (wr == 2'd2) ? 2 : 1;
    endfunction

    function automatic logic [31:0] ext(input logic [3:0] rd, input logic [31:0] a, input logic [31:0] rdat);
        logic [31:0] b, h;
        int          lane;
        lane = int'(a % 4);
        b = (rdat >> (8 * lane)) & 32'hFF;
        h = (rdat >> (16 * (lane / 2))) & 32'hFFFF;
        case (rd)
            4'd1:    return rdat;
            4'd2:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            4'd3:    return h;
            4'd4:    return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
            default: return b;
        endcase
    endfunction

    // Called at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
    task automatic do_access(input logic [3:0] rd, input logic [1:0] wr, input logic v,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ack_dly, input logic [31:0] rdat);
        bit          ld, st, acc, al, acked;
        int          sz;
        logic [31:0] e_be, e_wd, e_addr;
        ld  = v && rd >= 4'd1 && rd <= 4'd5;
        st  = v && !ld && wr != 2'd0;
        acc = ld || st;
        sz  = op_size(ld, rd, wr);
        al  = (a % sz) == 0;
        e_addr = a - (a % 4);
        e_be   = 32'hF;
        e_wd   = wd;
        if (st && sz == 2) begin
            e_be = ((a % 4) < 2) ? 32'h3 : 32'hC;
            e_wd = (wd & 32'hFFFF) * 32'h0001_0001;
        end else if (st && sz == 1) begin
            e_be = 32'h1 << (a % 4);
            e_wd = (wd & 32'hFF) * 32'h0101_0101;
        end
        exmem_valid = v; exmem_dmrd = rd; exmem_dmwr = wr;
        exmem_addr = a; exmem_wdata = wd; mem_ack = 1'b0;
        #1;
        chk("stall_detect", 32'(mem_stall), 32'(acc && al));
        if (!acc || !al) begin
            @(negedge clk);
            chk("misalign", 32'(misalign_err), 32'(acc && !al));
            chk("no_req", 32'(mem_req), 32'h0);
            chk("no_lvalid", 32'(load_valid), 32'h0);
            chk("ld_hold", load_data, exp_ld);
            exmem_valid = 1'b0;
            return;
        end
        acked = 1'b0;
        for (int n = 0; n < TO; n++) begin
            @(negedge clk);
            chk("busy_req", 32'(mem_req), 32'h1);
            chk("busy_stall", 32'(mem_stall), 32'h1);
            chk("busy_addr", mem_addr, e_addr);
            chk("busy_we", 32'(mem_we), 32'(st));
            chk("busy_be", 32'(mem_be), e_be);
            if (st) chk("busy_wdata", mem_wdata, e_wd);
            if (n == ack_dly) begin
                mem_ack = 1'b1; mem_rdata = rdat; acked = 1'b1;
                break;
            end
        end
        @(negedge clk);
        if (ld) exp_ld = acked ? ext(rd, a, rdat) : 32'h0;
        chk("done_stall", 32'(mem_stall), 32'h0);
        chk("done_req", 32'(mem_req), 32'h0);
        chk("done_lvalid", 32'(load_valid), 32'(ld));
        chk("done_buserr", 32'(bus_err), 32'(!acked));
        chk("done_ldata", load_data, exp_ld);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_lvalid", 32'(load_valid), 32'h0);
        chk("idle_buserr", 32'(bus_err), 32'h0);
        chk("idle_ldata", load_data, exp_ld);
        exmem_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
        exmem_valid = 1'b1; exmem_dmrd = 4'd1; exmem_dmwr = 2'd0;
        exmem_addr = 32'h100; exmem_wdata = 32'h0;
        @(negedge clk); @(negedge clk);
        chk("rst_stall", 32'(mem_stall), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_ldata", load_data, 32'h0);
        chk("rst_lvalid", 32'(load_valid), 32'h0);
        chk("rst_errs", {30'h0, misalign_err, bus_err}, 32'h0);
        rst = 1'b0; exmem_valid = 1'b0;
        @(negedge clk);

        do_access(4'd4, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80FF_0000);
        chk("lb_value", load_data, 32'hFFFF_FF80);
        do_access(4'd0, 2'd2, 1'b1, 32'h202, 32'h1234_ABCD, 1, 32'h0);
        do_access(4'd1, 2'd0, 1'b1, 32'h101, 32'h0, 0, 32'h0);
        do_access(4'd1, 2'd0, 1'b1, 32'h40, 32'h0, 99, 32'h0);
        chk("timeout_ldata", load_data, 32'h0);
        do_access(4'd5, 2'd0, 1'b1, 32'h3, 32'h0, 0, 32'hAA00_0000);
        chk("lbu_value", load_data, 32'h0000_00AA);
        do_access(4'd0, 2'd3, 1'b1, 32'h1, 32'h5A, 0, 32'h0);
        do_access(4'd2, 2'd1, 1'b1, 32'h6, 32'h0, TO - 1, 32'h8001_1234);
        chk("ack_at_timeout", load_data, 32'hFFFF_8001);

        // Reset while an access is outstanding.
        exmem_valid = 1'b1; exmem_dmrd = 4'd1; exmem_dmwr = 2'd0; exmem_addr = 32'h80;
        #1;
        chk("mr_stall", 32'(mem_stall), 32'h1);
        @(negedge clk);
        chk("mr_busy", 32'(mem_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mr_req", 32'(mem_req), 32'h0);
        chk("mr_stall0", 32'(mem_stall), 32'h0);
        chk("mr_addr", mem_addr, 32'h0);
        chk("mr_be_we", {27'h0, mem_we, mem_be}, 32'h0);
        chk("mr_ldata", load_data, 32'h0);
        exp_ld = 32'h0;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b0; exmem_valid = 1'b0;
        @(negedge clk);
        chk("mr_late_ack_lv", 32'(load_valid), 32'h0);
        chk("mr_late_ack_req", 32'(mem_req), 32'h0);
        chk("mr_late_ack_ld", load_data, 32'h0);
        mem_ack = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            do_access(4'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 7) != 0), $urandom & 32'hFFFF,
                      $urandom, int'($urandom_range(0, 5)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_access_unit
`default_nettype wire
